// File: rtl/lz4_pkg.sv
// Shared LZ4 compressor definitions: minimum match, distance limit and
// the match-extension FSM encoding.
package lz4_pkg;

  localparam int unsigned MIN_MATCH    = 4;
  localparam logic [31:0] LZ4_MAX_DIST = 32'd65535;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CMP  = 2'd2,
    OUT  = 2'd3
  } me_state_e;

endpackage

// File: rtl/byte_match_cnt.sv
// Counts leading bytes (from byte 0) that are both valid and equal in two words.
module byte_match_cnt (
  input  logic [31:0] word_a,
  input  logic [31:0] word_b,
  input  logic [3:0]  byte_vld,
  output logic [2:0]  n
);

  logic run;

  always_comb begin
    n   = 3'd0;
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (run && byte_vld[i] && (word_a[8*i +: 8] == word_b[8*i +: 8])) begin
        n = n + 3'd1;
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/match_extend.sv
// Extends a confirmed 4-byte hash hit forward one window word at a time and
// emits a (start, offset, length) sequence.
module match_extend
  import lz4_pkg::*;
#(
  parameter logic [15:0] MAX_MLEN = 16'hFFFF,
  parameter logic [31:0] MAX_DIST = LZ4_MAX_DIST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hit_valid,
  output logic        hit_ready,
  input  logic        hash_hit,
  input  logic [31:0] hash_oaddr,
  input  logic [31:0] hash_iaddr,
  input  logic [31:0] hit_dist,
  input  logic [31:0] src_end,
  output logic [31:0] win_raddr_a,
  input  logic [31:0] win_rdata_a,
  output logic [31:0] win_raddr_b,
  input  logic [31:0] win_rdata_b,
  output logic        seq_valid,
  input  logic        seq_ready,
  output logic [31:0] seq_start,
  output logic [15:0] seq_offset,
  output logic [15:0] seq_mlen
);

  me_state_e   state, state_nxt;
  logic [31:0] cur, ref_addr;
  logic [15:0] mlen;
  logic [3:0]  byte_vld;
  logic [2:0]  n;
  logic        hit_legal;
  logic        accept;
  logic        more_vld;
  logic [31:0] cur_step;
  logic [16:0] mlen_step;

  assign hit_ready   = (state == IDLE);
  assign seq_valid   = (state == OUT);
  assign seq_mlen    = mlen;
  assign win_raddr_a = ref_addr;
  assign win_raddr_b = cur;

  assign hit_legal = hash_hit && (hit_dist != 32'd0) && (hit_dist <= MAX_DIST);
  assign accept    = hit_valid && hit_ready && hit_legal;

  // A byte may extend the match only inside the source and under the length cap.
  always_comb begin
    byte_vld = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      byte_vld[i] = ((cur + 32'(i)) < src_end) &&
                    (({1'b0, mlen} + 17'(i)) < {1'b0, MAX_MLEN});
    end
  end

  // After a full 4-byte step, byte 0 of the next word decides whether to go on.
  assign cur_step  = cur + 32'd4;
  assign mlen_step = {1'b0, mlen} + 17'd4;
  assign more_vld  = (cur_step < src_end) && (mlen_step < {1'b0, MAX_MLEN});

  byte_match_cnt u_cnt (
    .word_a   (win_rdata_a),
    .word_b   (win_rdata_b),
    .byte_vld (byte_vld),
    .n        (n)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = READ;
      READ: state_nxt = CMP;
      CMP:  state_nxt = ((n == 3'd4) && more_vld) ? READ : OUT;
      OUT:  if (seq_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cur        <= 32'd0;
      ref_addr   <= 32'd0;
      mlen       <= 16'd0;
      seq_start  <= 32'd0;
      seq_offset <= 16'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        seq_start  <= hash_iaddr;
        seq_offset <= hit_dist[15:0];
        mlen       <= 16'(MIN_MATCH);
        cur        <= hash_iaddr + 32'(MIN_MATCH);
        ref_addr   <= hash_oaddr + 32'(MIN_MATCH);
      end else if (state == CMP) begin
        mlen     <= mlen + {13'd0, n};
        cur      <= cur + {29'd0, n};
        ref_addr <= ref_addr + {29'd0, n};
      end
    end
  end

endmodule

// File: tb/tb_match_extend.sv
// Directed bench for match_extend with a byte-addressed window model.
module tb_match_extend;

  logic        clk = 1'b0;
  logic        rst;
  logic        hit_valid, hit_valid2, hash_hit;
  logic [31:0] hash_oaddr, hash_iaddr, hit_dist, src_end;
  logic        seq_ready, seq_ready2;

  logic        hit_ready, seq_valid;
  logic [31:0] win_raddr_a, win_raddr_b, win_rdata_a, win_rdata_b, seq_start;
  logic [15:0] seq_offset, seq_mlen;

  logic        hit_ready2, seq_valid2;
  logic [31:0] win_raddr_a2, win_raddr_b2, win_rdata_a2, win_rdata_b2, seq_start2;
  logic [15:0] seq_offset2, seq_mlen2;

  logic [7:0]  mem [0:4095];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  match_extend dut (
    .clk(clk), .rst(rst), .hit_valid(hit_valid), .hit_ready(hit_ready),
    .hash_hit(hash_hit), .hash_oaddr(hash_oaddr), .hash_iaddr(hash_iaddr),
    .hit_dist(hit_dist), .src_end(src_end),
    .win_raddr_a(win_raddr_a), .win_rdata_a(win_rdata_a),
    .win_raddr_b(win_raddr_b), .win_rdata_b(win_rdata_b),
    .seq_valid(seq_valid), .seq_ready(seq_ready), .seq_start(seq_start),
    .seq_offset(seq_offset), .seq_mlen(seq_mlen)
  );

  match_extend #(.MAX_MLEN(16'd8)) dut8 (
    .clk(clk), .rst(rst), .hit_valid(hit_valid2), .hit_ready(hit_ready2),
    .hash_hit(hash_hit), .hash_oaddr(hash_oaddr), .hash_iaddr(hash_iaddr),
    .hit_dist(hit_dist), .src_end(src_end),
    .win_raddr_a(win_raddr_a2), .win_rdata_a(win_rdata_a2),
    .win_raddr_b(win_raddr_b2), .win_rdata_b(win_rdata_b2),
    .seq_valid(seq_valid2), .seq_ready(seq_ready2), .seq_start(seq_start2),
    .seq_offset(seq_offset2), .seq_mlen(seq_mlen2)
  );

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {mem[12'(a + 32'd3)], mem[12'(a + 32'd2)], mem[12'(a + 32'd1)], mem[12'(a)]};
  endfunction

  always @(posedge clk) begin
    win_rdata_a  <= rd_word(win_raddr_a);
    win_rdata_b  <= rd_word(win_raddr_b);
    win_rdata_a2 <= rd_word(win_raddr_a2);
    win_rdata_b2 <= rd_word(win_raddr_b2);
  end

  // Make nmatch bytes after the hashed 4 equal, then force the next one to differ.
  task automatic setup_match(input int oa, input int ia, input int nmatch);
    for (int k = 0; k < 4 + nmatch; k++) mem[12'(ia + k)] = mem[12'(oa + k)];
    mem[12'(ia + 4 + nmatch)] = ~mem[12'(oa + 4 + nmatch)];
  endtask

  task automatic offer(input bit sel, input logic [31:0] ia, input logic [31:0] oa,
                       input logic hh);
    hash_iaddr = ia;
    hash_oaddr = oa;
    hit_dist   = ia - oa;
    hash_hit   = hh;
    if (sel) hit_valid2 = 1'b1;
    else     hit_valid  = 1'b1;
    @(posedge clk); #1;
    hit_valid  = 1'b0;
    hit_valid2 = 1'b0;
  endtask

  task automatic run_hit(input bit sel, input logic [31:0] ia, input logic [31:0] oa,
                         output int edges);
    offer(sel, ia, oa, 1'b1);
    edges = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (sel ? seq_valid2 : seq_valid) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic consume(input bit sel);
    if (sel) seq_ready2 = 1'b1;
    else     seq_ready  = 1'b1;
    @(posedge clk); #1;
    seq_ready  = 1'b0;
    seq_ready2 = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (seq_valid !== 1'b0) begin errors++; $display("FAIL rst_seq_valid got %0h want 0", seq_valid); end
    checks++; if (seq_mlen !== 16'd0 || seq_offset !== 16'd0 || seq_start !== 32'd0) begin
      errors++; $display("FAIL rst_seq_fields got %0h/%0h/%0h want 0/0/0", seq_mlen, seq_offset, seq_start); end
    checks++; if (win_raddr_a !== 32'd0 || win_raddr_b !== 32'd0) begin
      errors++; $display("FAIL rst_raddr got %0h/%0h want 0/0", win_raddr_a, win_raddr_b); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (hit_ready !== 1'b1) begin errors++; $display("FAIL rst_hit_ready got %0h want 1", hit_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int e;
    setup_match(32'h0F0, 32'h100, 2);
    run_hit(1'b0, 32'h100, 32'h0F0, e);
    checks++; if (e !== 2) begin errors++; $display("FAIL basic_latency got %0d want 2", e); end
    checks++; if (seq_mlen !== 16'd6) begin errors++; $display("FAIL basic_mlen got %0d want 6", seq_mlen); end
    checks++; if (seq_offset !== 16'h0010) begin errors++; $display("FAIL basic_offset got %0h want 10", seq_offset); end
    checks++; if (seq_start !== 32'h100) begin errors++; $display("FAIL basic_start got %0h want 100", seq_start); end
    @(posedge clk); #1;
    checks++; if (seq_valid !== 1'b1 || seq_mlen !== 16'd6) begin
      errors++; $display("FAIL basic_hold got %0h/%0d want 1/6", seq_valid, seq_mlen); end
    consume(1'b0);
    checks++; if (seq_valid !== 1'b0 || hit_ready !== 1'b1) begin
      errors++; $display("FAIL basic_release got %0h/%0h want 0/1", seq_valid, hit_ready); end
  endtask

  task automatic test_long;
    int e;
    setup_match(32'h1C0, 32'h200, 13);
    run_hit(1'b0, 32'h200, 32'h1C0, e);
    checks++; if (e !== 8) begin errors++; $display("FAIL long_latency got %0d want 8", e); end
    checks++; if (seq_mlen !== 16'd17) begin errors++; $display("FAIL long_mlen got %0d want 17", seq_mlen); end
    checks++; if (seq_offset !== 16'h0040) begin errors++; $display("FAIL long_offset got %0h want 40", seq_offset); end
    consume(1'b0);
  endtask

  task automatic test_src_end;
    int e;
    setup_match(32'h0F0, 32'h100, 20);
    src_end = 32'h10A;
    run_hit(1'b0, 32'h100, 32'h0F0, e);
    checks++; if (seq_mlen !== 16'd10) begin errors++; $display("FAIL srcend_mlen got %0d want 10", seq_mlen); end
    checks++; if (e !== 4) begin errors++; $display("FAIL srcend_latency got %0d want 4", e); end
    checks++; if (win_raddr_b !== 32'h10A) begin errors++; $display("FAIL srcend_cur got %0h want 10a", win_raddr_b); end
    consume(1'b0);
    src_end = 32'h104;
    run_hit(1'b0, 32'h100, 32'h0F0, e);
    checks++; if (seq_mlen !== 16'd4 || e !== 2) begin
      errors++; $display("FAIL srcend_edge got %0d/%0d want 4/2", seq_mlen, e); end
    consume(1'b0);
    src_end = 32'h1000;
  endtask

  task automatic test_drop;
    logic [31:0] oas [3];
    logic        hhs [3];
    int e;
    oas[0] = 32'hFFFF_0100; hhs[0] = 1'b1;
    oas[1] = 32'h0000_00F0; hhs[1] = 1'b0;
    oas[2] = 32'h0000_0100; hhs[2] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      offer(1'b0, 32'h100, oas[c], hhs[c]);
      for (int k = 0; k < 4; k++) begin
        checks++; if (seq_valid !== 1'b0 || hit_ready !== 1'b1) begin
          errors++; $display("FAIL drop%0d got valid=%0h ready=%0h want 0/1", c, seq_valid, hit_ready); end
        @(posedge clk); #1;
      end
    end
    // Distance exactly at the limit is legal; first byte after the hash differs.
    mem[12'h105] = mem[12'h104] + 8'd1;
    run_hit(1'b0, 32'h100, 32'hFFFF_0101, e);
    checks++; if (e !== 2 || seq_mlen !== 16'd4 || seq_offset !== 16'hFFFF) begin
      errors++; $display("FAIL maxdist got e=%0d mlen=%0d off=%0h want 2/4/ffff", e, seq_mlen, seq_offset); end
    consume(1'b0);
  endtask

  task automatic test_max_mlen;
    int e;
    setup_match(32'h0F0, 32'h100, 40);
    run_hit(1'b1, 32'h100, 32'h0F0, e);
    checks++; if (e !== 2 || seq_mlen2 !== 16'd8) begin
      errors++; $display("FAIL maxmlen got e=%0d mlen=%0d want 2/8", e, seq_mlen2); end
    checks++; if (seq_valid !== 1'b0) begin errors++; $display("FAIL maxmlen_other got %0h want 0", seq_valid); end
    consume(1'b1);
  endtask

  task automatic test_reset_in_out;
    int e;
    setup_match(32'h0F0, 32'h100, 2);
    run_hit(1'b0, 32'h100, 32'h0F0, e);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++; if (seq_valid !== 1'b1 || seq_mlen !== 16'd6) begin
        errors++; $display("FAIL out_stall got %0h/%0d want 1/6", seq_valid, seq_mlen); end
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (seq_valid !== 1'b0 || seq_mlen !== 16'd0 || hit_ready !== 1'b1) begin
      errors++; $display("FAIL out_reset got %0h/%0d/%0h want 0/0/1", seq_valid, seq_mlen, hit_ready); end
    @(posedge clk); #1 rst = 1'b0;
    run_hit(1'b0, 32'h100, 32'h0F0, e);
    checks++; if (e !== 2 || seq_mlen !== 16'd6) begin
      errors++; $display("FAIL after_reset got e=%0d mlen=%0d want 2/6", e, seq_mlen); end
    consume(1'b0);
  endtask

  task automatic test_back_to_back;
    int e;
    setup_match(32'h1C0, 32'h200, 5);
    run_hit(1'b0, 32'h200, 32'h1C0, e);
    checks++; if (e !== 4 || seq_mlen !== 16'd9) begin
      errors++; $display("FAIL b2b_first got e=%0d mlen=%0d want 4/9", e, seq_mlen); end
    consume(1'b0);
    setup_match(32'h300, 32'h320, 0);
    run_hit(1'b0, 32'h320, 32'h300, e);
    checks++; if (e !== 2 || seq_mlen !== 16'd4 || seq_start !== 32'h320 || seq_offset !== 16'h0020) begin
      errors++; $display("FAIL b2b_second got e=%0d mlen=%0d start=%0h off=%0h want 2/4/320/20",
                         e, seq_mlen, seq_start, seq_offset); end
    consume(1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
    rst = 1'b1;
    hit_valid = 1'b0; hit_valid2 = 1'b0; hash_hit = 1'b0;
    hash_oaddr = '0; hash_iaddr = '0; hit_dist = '0;
    src_end = 32'h1000;
    seq_ready = 1'b0; seq_ready2 = 1'b0;
    test_reset();
    test_basic();
    test_long();
    test_src_end();
    test_drop();
    test_max_mlen();
    test_reset_in_out();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
